// File: rtl/ordinator_driver_8bit_if.sv
// Host-side bus of the calculator token driver: buffer loading, token output to the
// calculator, and the calculator's ready/result return path.
interface ordinator_driver_8bit_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       start;
  logic [7:0] out;
  logic       out_valid;
  logic       calc_ready;
  logic [7:0] calc_result;
  logic [7:0] result;
  logic       done;
  logic       error;
  logic       busy;

  // master: the host that loads and starts; slave: the driver itself
  modport master (
    output load_valid, load_data, start, calc_ready, calc_result,
    input  load_ready, out, out_valid, result, done, error, busy
  );

  modport slave (
    input  load_valid, load_data, start, calc_ready, calc_result,
    output load_ready, out, out_valid, result, done, error, busy
  );
endinterface

// File: rtl/ordinator_driver_8bit.sv
// Token-stream initiator for the 8-bit calculator: buffers an expression, replays it
// one token per clock, then captures the result. Define ORDINATOR_DRV_CHECK_EN to reject bad operators.
//
// state | meaning
// IDLE  | accepting tokens into the buffer, waiting for start
// EMIT  | out holds a valid token this cycle; next one is popped at the edge
// WAIT  | EQL sent, waiting for calc_ready or timeout
// DONE  | one-cycle completion, buffer flushed
module ordinator_driver_8bit #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ordinator_driver_8bit_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [7:0]    OP_EQL   = 8'd2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] idx;
  logic [AW:0]   count;
  logic [TW-1:0] tcnt;
  logic [7:0]    out_q;
  logic [7:0]    result_q;
  logic          out_valid_q;
  logic          error_q;
  logic          load_ready_c;
  logic          wr_en;
  logic          at_eql;
  logic [7:0]    head;

  assign load_ready_c = (state == IDLE) && (count < CNT_FULL);
  assign wr_en        = bus.load_valid && load_ready_c;
  // A token written in the start cycle of an empty buffer is forwarded straight to out
  assign head         = (count == '0) ? bus.load_data : mem[rd_ptr];
  assign at_eql       = idx[0] && (out_q == OP_EQL);

`ifdef ORDINATOR_DRV_CHECK_EN
  logic bad_op;
  assign bad_op = !idx[0] && (mem[rd_ptr] > OP_EQL);
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      idx         <= '0;
      count       <= '0;
      tcnt        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) wr_ptr <= wr_ptr + 1'b1;
          if (bus.start && ((count != '0) || wr_en)) begin
            out_q       <= head;
            out_valid_q <= 1'b1;
            rd_ptr      <= rd_ptr + 1'b1;
            if (!wr_en) count <= count - 1'b1;
            idx         <= '0;
            error_q     <= 1'b0;
            state       <= EMIT;
          end else if (wr_en) begin
            count <= count + 1'b1;
          end
        end
        EMIT: begin
          if (at_eql) begin
            out_valid_q <= 1'b0;
            tcnt        <= '0;
            state       <= WAIT;
          end else if (count == '0) begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b1;
            state       <= DONE;
          end
`ifdef ORDINATOR_DRV_CHECK_EN
          else if (bad_op) begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b1;
            state       <= DONE;
          end
`endif
          else begin
            out_q  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            idx    <= idx + 1'b1;
          end
        end
        WAIT: begin
          if (bus.calc_ready) begin
            result_q <= bus.calc_result;
            state    <= DONE;
          end else if (tcnt == T_LAST) begin
            error_q <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.done       = (state == DONE);
  assign bus.error      = error_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_ordinator_driver_8bit.sv
// Directed bench for ordinator_driver_8bit: load/emit/wait/done sequencing, timeout,
// missing EQL, full buffer, reset abort and the optional operator check.
module tb_ordinator_driver_8bit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ordinator_driver_8bit_if bus ();

  ordinator_driver_8bit #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    cyc();
    bus.load_valid = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    checks++; if (bus.out !== 8'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", bus.out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", bus.result); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.error); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [7:0] tok [4] = '{8'd5, 8'd0, 8'd3, 8'd2};
    for (int i = 0; i < 4; i++) load_byte(tok[i]);
    start_run();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out !== tok[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_tok%0d: got %0d/%b want %0d/1", i, bus.out, bus.out_valid, tok[i]); end
      checks++; if (i == 0 && bus.error !== 1'b0) begin errors++; $display("FAIL basic_error_emit: got %b want 0", bus.error); end
      cyc();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.out !== 8'd2) begin errors++; $display("FAIL basic_wait_out: got %0d/%b want 2/0", bus.out, bus.out_valid); end
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL basic_wait_state: busy %b done %b want 1 0", bus.busy, bus.done); end
    cyc();
    bus.calc_ready  = 1'b1;
    bus.calc_result = 8'd8;
    cyc();
    bus.calc_ready  = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.done); end
    checks++; if (bus.result !== 8'd8) begin errors++; $display("FAIL basic_result: got %0d want 8", bus.result); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", bus.error); end
    cyc();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_after_done: done %b busy %b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_timeout();
    logic [7:0] tok [6] = '{8'd10, 8'd1, 8'd4, 8'd0, 8'd1, 8'd2};
    for (int i = 0; i < 6; i++) load_byte(tok[i]);
    start_run();
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.out !== tok[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL timeout_tok%0d: got %0d/%b want %0d/1", i, bus.out, bus.out_valid, tok[i]); end
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL timeout_wait%0d: done %b busy %b want 0 1", i, bus.done, bus.busy); end
      cyc();
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL timeout_done: got %b want 1", bus.done); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", bus.error); end
    checks++; if (bus.result !== 8'd8) begin errors++; $display("FAIL timeout_result_kept: got %0d want 8", bus.result); end
    cyc();
    checks++; if (bus.error !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL timeout_sticky: error %b done %b want 1 0", bus.error, bus.done); end
  endtask

  task automatic test_no_eql();
    logic [7:0] tok [3] = '{8'd7, 8'd0, 8'd3};
    for (int i = 0; i < 3; i++) load_byte(tok[i]);
    bus.calc_ready  = 1'b1;
    bus.calc_result = 8'h55;
    start_run();
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL noeql_error_cleared: got %b want 0", bus.error); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out !== tok[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL noeql_tok%0d: got %0d/%b want %0d/1", i, bus.out, bus.out_valid, tok[i]); end
      cyc();
    end
    checks++; if (bus.done !== 1'b1 || bus.error !== 1'b1) begin errors++; $display("FAIL noeql_done: done %b error %b want 1 1", bus.done, bus.error); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL noeql_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 8'd8) begin errors++; $display("FAIL noeql_result: got %0d want 8", bus.result); end
    cyc();
    bus.calc_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL noeql_idle: busy %b want 0", bus.busy); end
  endtask

  task automatic test_start_write();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL empty_start_ignored: busy %b want 0", bus.busy); end
    bus.load_valid = 1'b1;
    bus.load_data  = 8'd6;
    bus.start      = 1'b1;
    cyc();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    checks++; if (bus.out !== 8'd6 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL samecycle_tok: got %0d/%b want 6/1", bus.out, bus.out_valid); end
    cyc();
    checks++; if (bus.done !== 1'b1 || bus.error !== 1'b1) begin errors++; $display("FAIL samecycle_done: done %b error %b want 1 1", bus.done, bus.error); end
    cyc();
  endtask

  task automatic test_full();
    logic [7:0] tok [8] = '{8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0, 8'd4, 8'd0};
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b want 1", i, bus.load_ready); end
      load_byte(tok[i]);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = 8'd2;
    #1;
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", bus.load_ready); end
    cyc();
    bus.load_valid = 1'b0;
    start_run();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out !== tok[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_tok%0d: got %0d/%b want %0d/1", i, bus.out, bus.out_valid, tok[i]); end
      cyc();
    end
    checks++; if (bus.done !== 1'b1 || bus.error !== 1'b1) begin errors++; $display("FAIL full_done: done %b error %b want 1 1", bus.done, bus.error); end
    cyc();
  endtask

  task automatic test_reset_mid();
    load_byte(8'd5);
    load_byte(8'd0);
    load_byte(8'd3);
    load_byte(8'd2);
    start_run();
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (bus.out !== 8'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out: got %0d/%b want 0/0", bus.out, bus.out_valid); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL rstmid_flags: busy %b done %b error %b want 0 0 0", bus.busy, bus.done, bus.error); end
    checks++; if (bus.result !== 8'd0 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL rstmid_result: result %0d load_ready %b want 0 1", bus.result, bus.load_ready); end
    #2;
    reset = 1'b1;
    cyc();
    start_run();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty_start: busy %b out_valid %b want 0 0", bus.busy, bus.out_valid); end
  endtask

  task automatic test_check_feature();
    logic [7:0] tok [4] = '{8'd5, 8'd3, 8'd1, 8'd2};
    for (int i = 0; i < 4; i++) load_byte(tok[i]);
    start_run();
`ifdef ORDINATOR_DRV_CHECK_EN
    checks++; if (bus.out !== 8'd5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL chk_tok0: got %0d/%b want 5/1", bus.out, bus.out_valid); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL chk_blocked: out_valid %b want 0", bus.out_valid); end
    checks++; if (bus.done !== 1'b1 || bus.error !== 1'b1) begin errors++; $display("FAIL chk_done: done %b error %b want 1 1", bus.done, bus.error); end
    cyc();
`else
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out !== tok[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL nochk_tok%0d: got %0d/%b want %0d/1", i, bus.out, bus.out_valid, tok[i]); end
      cyc();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL nochk_wait: out_valid %b busy %b done %b want 0 1 0", bus.out_valid, bus.busy, bus.done); end
    bus.calc_ready  = 1'b1;
    bus.calc_result = 8'h21;
    cyc();
    bus.calc_ready  = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.result !== 8'h21 || bus.error !== 1'b0) begin errors++; $display("FAIL nochk_done: done %b result %0d error %b want 1 33 0", bus.done, bus.result, bus.error); end
    cyc();
`endif
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = 8'd0;
    bus.start       = 1'b0;
    bus.calc_ready  = 1'b0;
    bus.calc_result = 8'd0;
    test_reset();
    test_basic();
    test_timeout();
    test_no_eql();
    test_start_write();
    test_full();
    test_reset_mid();
    test_check_feature();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
